// File: rtl/incarcator_program.sv
// Program loader: receives a length-prefixed stream of 16-bit instructions over a
// byte handshake, writes them to instruction memory and releases the CPU on success.
module incarcator_program #(
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [7:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [7:0]  len_q;
  logic [7:0]  addr_q;
  logic [7:0]  hi_q;
  logic [7:0]  chk_q;
  logic        mem_we_q;
  logic [7:0]  mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        error_q;
  logic [7:0]  words_q;
  logic        xfer;

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_LEN, S_HI, S_LO, S_CHK: rx_ready = 1'b1;
      default:                  rx_ready = 1'b0;
    endcase
  end

  assign xfer = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      hi_q        <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q     <= S_LEN;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            words_q     <= '0;
            chk_q       <= '0;
            cpu_reset_q <= 1'b1;
          end else if (state_q == S_DONE) begin
            // Entering DONE straight from LO leaves done low for the strobe cycle.
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            if (rx_data == 8'h00) begin
              state_q     <= S_ERR;
              error_q     <= 1'b1;
              done_q      <= 1'b0;
              cpu_reset_q <= 1'b1;
            end else begin
              len_q   <= rx_data;
              addr_q  <= '0;
              chk_q   <= rx_data;
              state_q <= S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_q    <= rx_data;
            chk_q   <= chk_q ^ rx_data;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            chk_q       <= chk_q ^ rx_data;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= {hi_q, rx_data};
            addr_q      <= addr_q + 8'd1;
            words_q     <= words_q + 8'd1;
            if ((words_q + 8'd1) < len_q) begin
              state_q <= S_HI;
            end else if (CHECKSUM_EN) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (rx_data == chk_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
              error_q     <= 1'b0;
            end else begin
              state_q     <= S_ERR;
              error_q     <= 1'b1;
              done_q      <= 1'b0;
              cpu_reset_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_incarcator_program.sv
// Scoreboard bench for incarcator_program: expected memory writes are queued by the
// stimulus and popped by an independent write monitor; status is checked after each load.
module tb_incarcator_program;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_w;
  logic [7:0]  s[$];

  incarcator_program #(.CHECKSUM_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   mem_addr, mem_wdata, exp_w[23:16], exp_w[15:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: byte %0h never accepted within 50 cycles", b);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_stream(input int gap);
    foreach (s[i]) send_byte(s[i], gap);
    rx_valid = 1'b0;
  endtask

  task automatic check_end(input string name, input logic d, input logic e,
                           input logic c, input logic [7:0] wl);
    repeat (3) @(negedge clk);
    chk({name, "_done"}, done, d);
    chk({name, "_error"}, error, e);
    chk({name, "_cpu_reset"}, cpu_reset, c);
    chk({name, "_words_loaded"}, words_loaded, wl);
    chk({name, "_missing_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_rx_ready"}, rx_ready, 0);
    chk({name, "_mem_we"}, mem_we, 0);
    chk({name, "_mem_addr"}, mem_addr, 0);
    chk({name, "_mem_wdata"}, mem_wdata, 0);
    chk({name, "_words_loaded"}, words_loaded, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_cpu_reset"}, cpu_reset, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clk);

    // Two-word load with correct checksum
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    pulse_start();
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_stream(0);
    check_end("good", 1'b1, 1'b0, 1'b0, 8'd2);

    // Bad checksum: words still written, then error
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    pulse_start();
    chk("restart_done_clear", done, 0);
    chk("restart_cpu_reset", cpu_reset, 1);
    chk("restart_words_clear", words_loaded, 0);
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    send_stream(0);
    check_end("badchk", 1'b0, 1'b1, 1'b1, 8'd2);

    // Zero length
    pulse_start();
    chk("zlen_error_clear", error, 0);
    s = '{8'h00};
    send_stream(0);
    chk("zlen_error_now", error, 1);
    check_end("zlen", 1'b0, 1'b1, 1'b1, 8'd0);

    // Gapped stream with an ignored mid-load start
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    pulse_start();
    send_byte(8'h02, 3);
    send_byte(8'h12, 3);
    pulse_start();
    send_byte(8'h34, 3);
    chk("gap_words_mid", words_loaded, 1);
    chk("gap_addr_mid", mem_addr, 0);
    chk("gap_done_mid", done, 0);
    pulse_start();
    send_byte(8'hAB, 3);
    send_byte(8'hCD, 3);
    send_byte(8'h42, 3);
    rx_valid = 1'b0;
    check_end("gap", 1'b1, 1'b0, 1'b0, 8'd2);

    // Reset mid-load after the first word
    exp_q.push_back({8'h00, 16'h1234});
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_reset_values("midreset");
    rx_data  = 8'hAB;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("midreset_hold_cpu", cpu_reset, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_idle_ready", rx_ready, 0);
    chk("midreset_no_pending", exp_q.size(), 0);
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    pulse_start();
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_stream(0);
    check_end("after_reset", 1'b1, 1'b0, 1'b0, 8'd2);

    // Reload from DONE: single word FF00, checksum 01^FF^00 = FE
    exp_q.push_back({8'h00, 16'hFF00});
    pulse_start();
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_done_clear", done, 0);
    s = '{8'h01, 8'hFF, 8'h00, 8'hFE};
    send_stream(0);
    check_end("reload", 1'b1, 1'b0, 1'b0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/incarcator_program.md
INCARCATOR_PROGRAM -- requirements
Module: incarcator_program

Interface
REQ-001 Parameter: CHECKSUM_EN, default 1, 1 = trailing checksum byte expected and checked, 0 = no checksum phase.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a program load; honoured only in IDLE, DONE, ERR.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  block accepts a byte this cycle.
REQ-008 mem_we  output  1  instruction-memory write strobe, one cycle per instruction.
REQ-009 mem_addr  output  8  instruction-memory word address.
REQ-010 mem_wdata  output  16  instruction word to write.
REQ-011 cpu_reset  output  1  active-high hold for the processor core; released only after a successful load.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  load failed (zero length or checksum mismatch).
REQ-014 words_loaded  output  8  count of instructions written in the current/last load.

Function
REQ-015 A byte SHALL transfer exactly on a rising edge where rx_valid and rx_ready are both 1; rx_ready SHALL be a function of current state only.
REQ-016 States SHALL be IDLE, LEN, HI, LO, CHK, DONE, ERR; rx_ready=1 only in LEN, HI, LO, CHK.
REQ-017 IDLE/DONE/ERR + start -> LEN; on that edge error, done, words_loaded and the checksum accumulator SHALL clear and cpu_reset SHALL go 1.
REQ-018 start in LEN, HI, LO, CHK SHALL be ignored.
REQ-019 LEN: accepted byte L; L==0 -> ERR; else store L, load address counter with 0, checksum = L, -> HI.
REQ-020 HI: accepted byte latched as instruction[15:8] -> LO.
REQ-021 LO: accepted byte forms instruction[7:0]; on the following cycle mem_we=1 for exactly one cycle with mem_addr = current address and mem_wdata = {hi, lo}; address and words_loaded then increment by 1.
REQ-022 After the LO handshake: if words_loaded+1 < L -> HI; else -> CHK when CHECKSUM_EN=1, else -> DONE.
REQ-023 Checksum SHALL be the 8-bit XOR of the length byte and every data byte accepted.
REQ-024 CHK: accepted byte equal to checksum -> DONE; otherwise -> ERR.
REQ-025 mem_addr SHALL span 0..L-1 and never wrap (L <= 255); no memory write SHALL occur outside LO-driven strobes.
REQ-026 DONE: done=1, cpu_reset=0, error=0; ERR: error=1, cpu_reset=1, done=0.
REQ-027 Gaps in rx_valid of any length SHALL stall the state machine with no state, address or checksum change.
REQ-028 mem_we, mem_addr, mem_wdata, cpu_reset, done, error, words_loaded SHALL be registered outputs.
REQ-029 The final word's mem_we cycle SHALL occur before done rises (done no earlier than one cycle after last mem_we).

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, done=0, error=0, cpu_reset=1.
REQ-031 Reset asserted mid-load SHALL abort with no further mem_we; after release the block waits in IDLE for start.

Verification
REQ-032 start; bytes 02,12,34,AB,CD,42 with rx_valid held 1 -> mem_we at addr 0 data 1234, addr 1 data ABCD; done=1, cpu_reset=0, words_loaded=2.
REQ-033 Same stream with checksum 43 -> both words written, then error=1, done=0, cpu_reset=1.
REQ-034 start; length byte 00 -> ERR immediately, no mem_we, error=1.
REQ-035 Same stream as REQ-032 with rx_valid low 3 cycles between every byte -> identical writes and final state; no extra strobes.
REQ-036 reset=0 after the first word written -> outputs at reset values immediately; start then full REQ-032 stream -> done=1.
REQ-037 From DONE, start then stream 01,FF,00,FE (CHECKSUM_EN=1) -> cpu_reset=1 during load, addr 0 data FF00, done=1, words_loaded=1.
